exu_branch_unit_bp: RTL and testbench
=====================================

Name: exu_branch_unit_bp

Overview:
Next-generation EXU branch unit for the PQR5 core.
- Resolves JAL/JALR/B-type instructions and registers branch status, target, bubble and flush toward the pipeline.
- Adds a parametrised Branch History Table (BHT) of saturating counters, trained at resolution and read combinationally by FU for dynamic prediction.
- Flushes on direction or target mismatch, so a correctly predicted JALR no longer flushes.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/PC width.
- PC_INIT, 32'h0, PC value loaded into PC-type output registers on reset.
- BHT_DEPTH, 64, number of BHT entries; power of 2, at least 2.
- BHT_CNT_W, 2, width of each saturating counter; at least 1.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- i_stall  in  1  stall; freezes all registers and the BHT
- i_pc  in  XLEN  PC of the instruction in EXU
- i_bubble  in  1  incoming bubble
- i_is_j_type  in  1  JAL flag
- i_is_b_type  in  1  B-type flag
- i_is_jalr  in  1  JALR flag
- i_funct3  in  3  funct3
- i_immJ  in  20  J immediate (imm[20:1])
- i_immI  in  12  I immediate
- i_immB  in  12  B immediate (imm[12:1])
- i_op0  in  XLEN  rs1 value
- i_op1  in  XLEN  rs2 value
- i_branch_taken  in  1  predicted direction carried from FU
- i_pred_pc  in  XLEN  predicted next PC carried from FU
- i_fu_pc  in  XLEN  FU lookup PC
- o_fu_pred_taken  out  1  BHT prediction for i_fu_pc (combinational)
- o_nxt_instr_pc  out  XLEN  registered PC+4
- o_bubble  out  1  registered bubble
- o_branch_taken  out  1  registered resolved direction
- o_branch_pc  out  XLEN  registered resolved next PC
- o_flush  out  1  registered flush
- o_br_cnt  out  STAT_W  resolved non-bubble control-transfer count
- o_mispred_cnt  out  STAT_W  flush count

Behaviour:
- Reset values, one cycle after reset=1 at a clock edge:
  - o_nxt_instr_pc = PC_INIT, o_branch_pc = PC_INIT.
  - o_bubble = 1, o_branch_taken = 0, o_flush = 0.
  - Both statistics counters = 0.
  - Every BHT entry = weakly-not-taken, i.e. 2^(BHT_CNT_W-1)-1; for BHT_CNT_W=1 this is 0.
- Reset has priority over i_stall. Reset mid-stream discards any in-flight resolution and performs no BHT write.
- Register update rule: registers and BHT update only when !i_stall. Latency is 1 cycle from inputs to all o_* except o_fu_pred_taken.
- Direction, one-hot decode of {j,jalr,b}:
  - JAL and JALR: always taken.
  - B-type: BEQ/BNE/BLT/BGE/BLTU/BGEU on op0 vs op1; signed compare for BLT/BGE.
  - Illegal funct3 or an invalid decode: not taken.
- Target:
  - JAL: pc + sext(immJ<<1).
  - JALR: (op0 + sext(immI)) with the LSb cleared.
  - B-type: taken ? pc + sext(immB<<1) : pc+4.
  - Otherwise: pc+4.
  - All arithmetic is modulo 2^XLEN and wraps silently.
- Flush = !i_bubble & ((taken != i_branch_taken) | (taken & (branch_pc != i_pred_pc))).
  - A not-taken result with a matching prediction never flushes, regardless of i_pred_pc.
- Bubble out = (JAL|JALR) ? i_bubble : 1.
- BHT:
  - Index = pc[$clog2(BHT_DEPTH)+1:2].
  - Update when !reset & !i_stall & !i_bubble & B-type with legal funct3: increment if taken, else decrement.
  - Counters saturate at 0 and at all-ones; no wrap.
  - JAL, JALR and illegal funct3 never train the BHT.
- o_fu_pred_taken = MSB of the entry at i_fu_pc's index. A same-cycle update to that entry is not visible; the old value is returned (read-before-write).
- Statistics counters:
  - o_br_cnt increments on a non-bubble JAL, JALR or B-type when !i_stall.
  - o_mispred_cnt increments whenever the flush value is 1 and !i_stall.
  - Both saturate at all-ones.
- Simultaneous events: a stall and a mispredict in the same cycle produce no flush registration until the first unstalled cycle, where they are re-evaluated on the then-current inputs.

Decomposition:
- pqr5_core_pkg holds:
  - F3_B* constants (existing).
  - A bht_cnt_t typedef sized by BHT_CNT_W.
  - A function returning the weakly-not-taken init value.
  - A function doing saturating increment/decrement.
- One sub-module, exu_bht: counter array, synchronous reset, write port, and asynchronous read port with read-before-write behaviour.
- Resolution, target and flush logic plus the statistics counters stay in the top module.

Test Plan:
- Reset with reset=1 for 2 cycles -> o_bubble=1, o_flush=0, o_branch_pc=PC_INIT, both counters 0, o_fu_pred_taken=0 for any i_fu_pc.
- BEQ at pc=0x100, op0=op1=5, immB=0x008, i_branch_taken=0 -> next cycle o_branch_taken=1, o_branch_pc=0x110, o_flush=1, o_mispred_cnt=1, o_bubble=1.
- Repeated BNE taken at pc=0x40, 4 times, no stall -> BHT entry 16 goes 1→2→3→3; o_fu_pred_taken for i_fu_pc=0x40 turns 1 after the first update and stays 1.
- JALR with op0=0x2001, immI=0x004, i_branch_taken=1, i_pred_pc=0x2004 -> o_flush=0, o_branch_pc=0x2004, o_nxt_instr_pc=pc+4; repeat with i_pred_pc=0x3000 -> o_flush=1.
- Mispredicted BLT with i_stall=1 for 3 cycles then released -> outputs and counters unchanged during the stall, update once on release, BHT written exactly once.
- Bubble B-type with i_bubble=1 and a mismatched prediction -> o_flush=0, no BHT or statistics change; mispredicts beyond 2^STAT_W-1 hold o_mispred_cnt at 0xFFFF.

Source files
------------

// File: rtl/pqr5_core_pkg.sv
// rtl/pqr5_core_pkg.sv - shared PQR5 core constants, BHT counter type and helpers
package pqr5_core_pkg;

  // B-type funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Default counter width and the widest counter the helpers handle
  localparam int BHT_CNT_W_DEF = 2;
  localparam int CNT_MAX_W     = 16;

  typedef logic [BHT_CNT_W_DEF-1:0] bht_cnt_t;

  // Weakly-not-taken value for a w-bit counter: 2^(w-1)-1 (0 when w=1)
  function automatic logic [CNT_MAX_W-1:0] bht_init_val(input int unsigned w);
    return (CNT_MAX_W'(1) << (w - 1)) - CNT_MAX_W'(1);
  endfunction

  // Saturating up/down step of a w-bit counter held in a wider vector
  function automatic logic [CNT_MAX_W-1:0] bht_sat_step(input logic [CNT_MAX_W-1:0] cnt,
                                                       input logic inc,
                                                       input int unsigned w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
    if (inc) return (cnt == max_v) ? cnt : cnt + CNT_MAX_W'(1);
    else     return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/exu_branch_unit_bp_bht.sv
// rtl/exu_branch_unit_bp_bht.sv - branch history table of saturating counters
module exu_bht
  import pqr5_core_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic             i_inc,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [CNT_W-1:0] o_rcnt
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(bht_init_val(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];

  // Next array state: one saturating step on the written entry
  always_comb begin
    cnt_d = cnt_q;
    if (i_we) begin
      cnt_d[i_widx] = CNT_W'(bht_sat_step(CNT_MAX_W'(cnt_q[i_widx]), i_inc, CNT_W));
    end
  end

  // Counter storage, reset to weakly-not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read port sees the pre-update value of a same-cycle write
  assign o_rcnt = cnt_q[i_ridx];

endmodule

// File: rtl/exu_branch_unit_bp.sv
// rtl/exu_branch_unit_bp.sv - EXU branch resolution with BHT training and statistics
module exu_branch_unit_bp
  import pqr5_core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] PC_INIT   = 32'h0,
  parameter int              BHT_DEPTH = 64,
  parameter int              BHT_CNT_W = BHT_CNT_W_DEF,
  parameter int              STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_bubble,
  input  logic              i_is_j_type,
  input  logic              i_is_b_type,
  input  logic              i_is_jalr,
  input  logic [2:0]        i_funct3,
  input  logic [19:0]       i_immJ,
  input  logic [11:0]       i_immI,
  input  logic [11:0]       i_immB,
  input  logic [XLEN-1:0]   i_op0,
  input  logic [XLEN-1:0]   i_op1,
  input  logic              i_branch_taken,
  input  logic [XLEN-1:0]   i_pred_pc,
  input  logic [XLEN-1:0]   i_fu_pc,
  output logic              o_fu_pred_taken,
  output logic [XLEN-1:0]   o_nxt_instr_pc,
  output logic              o_bubble,
  output logic              o_branch_taken,
  output logic [XLEN-1:0]   o_branch_pc,
  output logic              o_flush,
  output logic [STAT_W-1:0] o_br_cnt,
  output logic [STAT_W-1:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic            dec_j, dec_jalr, dec_b, f3_legal;
  logic            res_taken, res_flush;
  logic [XLEN-1:0] pc_plus4, res_target;

  logic [XLEN-1:0]   nxt_instr_pc_q, nxt_instr_pc_d;
  logic              bubble_q, bubble_d;
  logic              branch_taken_q, branch_taken_d;
  logic [XLEN-1:0]   branch_pc_q, branch_pc_d;
  logic              flush_q, flush_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic                 bht_we;
  logic [BHT_CNT_W-1:0] bht_rcnt;

  assign pc_plus4 = i_pc + XLEN'(4);

  // Decode one-hot instruction class, resolve direction and next PC
  always_comb begin
    dec_j      = ({i_is_j_type, i_is_jalr, i_is_b_type} == 3'b100);
    dec_jalr   = ({i_is_j_type, i_is_jalr, i_is_b_type} == 3'b010);
    dec_b      = ({i_is_j_type, i_is_jalr, i_is_b_type} == 3'b001);
    f3_legal   = 1'b1;
    res_taken  = 1'b0;
    res_target = pc_plus4;
    unique case (i_funct3)
      F3_BEQ:  res_taken = dec_b & (i_op0 == i_op1);
      F3_BNE:  res_taken = dec_b & (i_op0 != i_op1);
      F3_BLT:  res_taken = dec_b & ($signed(i_op0) <  $signed(i_op1));
      F3_BGE:  res_taken = dec_b & ($signed(i_op0) >= $signed(i_op1));
      F3_BLTU: res_taken = dec_b & (i_op0 <  i_op1);
      F3_BGEU: res_taken = dec_b & (i_op0 >= i_op1);
      default: f3_legal  = 1'b0;
    endcase
    if (dec_j) begin
      res_taken  = 1'b1;
      res_target = i_pc + {{(XLEN-21){i_immJ[19]}}, i_immJ, 1'b0};
    end else if (dec_jalr) begin
      res_taken  = 1'b1;
      res_target = (i_op0 + {{(XLEN-12){i_immI[11]}}, i_immI}) & ~XLEN'(1);
    end else if (dec_b && res_taken) begin
      res_target = i_pc + {{(XLEN-13){i_immB[11]}}, i_immB, 1'b0};
    end
    res_flush = ~i_bubble & ((res_taken != i_branch_taken) |
                             (res_taken & (res_target != i_pred_pc)));
  end

  // Next register values; a stall holds everything
  always_comb begin
    nxt_instr_pc_d = nxt_instr_pc_q;
    bubble_d       = bubble_q;
    branch_taken_d = branch_taken_q;
    branch_pc_d    = branch_pc_q;
    flush_d        = flush_q;
    br_cnt_d       = br_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (!i_stall) begin
      nxt_instr_pc_d = pc_plus4;
      bubble_d       = (dec_j | dec_jalr) ? i_bubble : 1'b1;
      branch_taken_d = res_taken;
      branch_pc_d    = res_target;
      flush_d        = res_flush;
      if (!i_bubble && (dec_j || dec_jalr || dec_b) && (br_cnt_q != '1))
        br_cnt_d = br_cnt_q + STAT_W'(1);
      if (res_flush && (mispred_cnt_q != '1))
        mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  // Output and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      nxt_instr_pc_q <= PC_INIT;
      bubble_q       <= 1'b1;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= PC_INIT;
      flush_q        <= 1'b0;
      br_cnt_q       <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      nxt_instr_pc_q <= nxt_instr_pc_d;
      bubble_q       <= bubble_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
      flush_q        <= flush_d;
      br_cnt_q       <= br_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  // Only legal, non-bubble conditional branches train the predictor
  assign bht_we = ~reset & ~i_stall & ~i_bubble & dec_b & f3_legal;

  exu_bht #(
    .DEPTH (BHT_DEPTH),
    .CNT_W (BHT_CNT_W)
  ) u_bht (
    .clk    (clk),
    .reset  (reset),
    .i_we   (bht_we),
    .i_widx (i_pc[IDX_W+1:2]),
    .i_inc  (res_taken),
    .i_ridx (i_fu_pc[IDX_W+1:2]),
    .o_rcnt (bht_rcnt)
  );

  assign o_fu_pred_taken = bht_rcnt[BHT_CNT_W-1];
  assign o_nxt_instr_pc  = nxt_instr_pc_q;
  assign o_bubble        = bubble_q;
  assign o_branch_taken  = branch_taken_q;
  assign o_branch_pc     = branch_pc_q;
  assign o_flush         = flush_q;
  assign o_br_cnt        = br_cnt_q;
  assign o_mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_exu_branch_unit_bp.sv
// tb/tb_exu_branch_unit_bp.sv - self-checking bench for exu_branch_unit_bp
module tb_exu_branch_unit_bp;

  logic        clk = 1'b0;
  logic        reset, i_stall, i_bubble;
  logic [31:0] i_pc, i_op0, i_op1, i_pred_pc, i_fu_pc;
  logic        i_is_j_type, i_is_b_type, i_is_jalr, i_branch_taken;
  logic [2:0]  i_funct3;
  logic [19:0] i_immJ;
  logic [11:0] i_immI, i_immB;
  logic        o_fu_pred_taken, o_bubble, o_branch_taken, o_flush;
  logic [31:0] o_nxt_instr_pc, o_branch_pc;
  logic [15:0] o_br_cnt, o_mispred_cnt;

  int total = 0;
  int bad   = 0;

  // reference state
  longint m_nxt, m_bpc, m_br, m_mp;
  bit     m_bub, m_tk, m_fl;
  int     m_bht [64];

  exu_branch_unit_bp dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_pc(i_pc), .i_bubble(i_bubble),
    .i_is_j_type(i_is_j_type), .i_is_b_type(i_is_b_type), .i_is_jalr(i_is_jalr),
    .i_funct3(i_funct3), .i_immJ(i_immJ), .i_immI(i_immI), .i_immB(i_immB),
    .i_op0(i_op0), .i_op1(i_op1), .i_branch_taken(i_branch_taken), .i_pred_pc(i_pred_pc),
    .i_fu_pc(i_fu_pc), .o_fu_pred_taken(o_fu_pred_taken), .o_nxt_instr_pc(o_nxt_instr_pc),
    .o_bubble(o_bubble), .o_branch_taken(o_branch_taken), .o_branch_pc(o_branch_pc),
    .o_flush(o_flush), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed value of an n-bit two's complement field
  function automatic longint sx(input longint v, input int n);
    return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
  endfunction

  // Architectural outcome of the instruction currently on the inputs
  task automatic resolve(output bit kind_ok, output bit is_ctl, output bit legal,
                         output bit taken, output longint tgt);
    int     nsel;
    longint a, b, sa, sb;
    nsel    = int'(i_is_j_type) + int'(i_is_jalr) + int'(i_is_b_type);
    kind_ok = (nsel == 1);
    is_ctl  = kind_ok;
    legal   = !(i_funct3 == 3'd2 || i_funct3 == 3'd3);
    a = longint'(i_op0); b = longint'(i_op1);
    sa = sx(a, 32); sb = sx(b, 32);
    taken = 0;
    tgt   = (longint'(i_pc) + 4) % (longint'(1) << 32);
    if (kind_ok && i_is_j_type) begin
      taken = 1;
      tgt = (longint'(i_pc) + 2 * sx(longint'(i_immJ), 20)) & 64'hFFFF_FFFF;
    end else if (kind_ok && i_is_jalr) begin
      taken = 1;
      tgt = ((a + sx(longint'(i_immI), 12)) & 64'hFFFF_FFFF) & ~64'd1;
    end else if (kind_ok && i_is_b_type && legal) begin
      case (i_funct3)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = (sa < sb);
        3'd5: taken = (sa >= sb);
        3'd6: taken = (a < b);
        default: taken = (a >= b);
      endcase
      if (taken) tgt = (longint'(i_pc) + 2 * sx(longint'(i_immB), 12)) & 64'hFFFF_FFFF;
    end
  endtask

  // Advance the reference by one clock using the present inputs
  task automatic model_edge();
    bit kind_ok, is_ctl, legal, taken;
    longint tgt;
    int idx;
    if (reset) begin
      m_nxt = 0; m_bpc = 0; m_bub = 1; m_tk = 0; m_fl = 0; m_br = 0; m_mp = 0;
      foreach (m_bht[k]) m_bht[k] = 1;
    end else if (!i_stall) begin
      resolve(kind_ok, is_ctl, legal, taken, tgt);
      m_fl  = !i_bubble && ((taken != i_branch_taken) || (taken && tgt != longint'(i_pred_pc)));
      m_tk  = taken;
      m_bpc = tgt;
      m_nxt = (longint'(i_pc) + 4) & 64'hFFFF_FFFF;
      m_bub = (kind_ok && !i_is_b_type) ? i_bubble : 1'b1;
      if (!i_bubble && is_ctl && m_br < 65535) m_br++;
      if (m_fl && m_mp < 65535) m_mp++;
      if (!i_bubble && kind_ok && i_is_b_type && legal) begin
        idx = int'(i_pc[7:2]);
        if (taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else       m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".nxt"},   o_nxt_instr_pc,  m_nxt);
    chk({tag, ".bpc"},   o_branch_pc,     m_bpc);
    chk({tag, ".bub"},   o_bubble,        m_bub);
    chk({tag, ".tk"},    o_branch_taken,  m_tk);
    chk({tag, ".flush"}, o_flush,         m_fl);
    chk({tag, ".brcnt"}, o_br_cnt,        m_br);
    chk({tag, ".mpcnt"}, o_mispred_cnt,   m_mp);
    chk({tag, ".fupred"}, o_fu_pred_taken, m_bht[i_fu_pc[7:2]] >= 2);
  endtask

  task automatic idle();
    i_stall = 0; i_bubble = 1; i_is_j_type = 0; i_is_b_type = 0; i_is_jalr = 0;
    i_funct3 = 0; i_immJ = 0; i_immI = 0; i_immB = 0; i_op0 = 0; i_op1 = 0;
    i_branch_taken = 0; i_pred_pc = 0; i_pc = 0;
  endtask

  initial begin
    int k;
    bit kind_ok, is_ctl, legal, taken;
    longint tgt;

    idle();
    reset = 1; i_fu_pc = 32'h0;
    #1;

    // reset held for two cycles
    step(); step();
    check_all("reset");
    for (int a = 0; a < 4; a++) begin
      i_fu_pc = $urandom; #1;
      chk("reset.fupred_any", o_fu_pred_taken, 1'b0);
    end
    reset = 0;

    // BEQ taken, predicted not-taken
    i_pc = 32'h100; i_bubble = 0; i_is_b_type = 1; i_funct3 = 3'b000;
    i_op0 = 5; i_op1 = 5; i_immB = 12'h008; i_branch_taken = 0;
    step();
    chk("beq.tk", o_branch_taken, 1'b1);
    chk("beq.bpc", o_branch_pc, 32'h110);
    chk("beq.flush", o_flush, 1'b1);
    chk("beq.mp", o_mispred_cnt, 16'd1);
    chk("beq.bub", o_bubble, 1'b1);
    check_all("beq");

    // BNE taken four times at pc 0x40 trains entry 16 to saturation
    i_pc = 32'h40; i_funct3 = 3'b001; i_op0 = 1; i_op1 = 2; i_fu_pc = 32'h40;
    i_immB = 12'h010; i_branch_taken = 1; i_pred_pc = 32'h60;
    #1;
    chk("bne.pre", o_fu_pred_taken, 1'b0);
    for (int r = 0; r < 4; r++) begin
      step();
      chk("bne.fupred", o_fu_pred_taken, 1'b1);
      chk("bne.flush", o_flush, 1'b0);
    end
    check_all("bne");

    // JALR predicted correctly, then wrong target
    idle(); i_fu_pc = 32'h40;
    i_pc = 32'h500; i_bubble = 0; i_is_jalr = 1; i_op0 = 32'h2001; i_immI = 12'h004;
    i_branch_taken = 1; i_pred_pc = 32'h2004;
    step();
    chk("jalr.flush", o_flush, 1'b0);
    chk("jalr.bpc", o_branch_pc, 32'h2004);
    chk("jalr.nxt", o_nxt_instr_pc, 32'h504);
    chk("jalr.bub", o_bubble, 1'b0);
    i_pred_pc = 32'h3000;
    step();
    chk("jalr2.flush", o_flush, 1'b1);
    check_all("jalr");

    // Mispredicted BLT held by a 3-cycle stall
    idle();
    i_pc = 32'h80; i_bubble = 0; i_is_b_type = 1; i_funct3 = 3'b100;
    i_op0 = 32'hFFFF_FFFF; i_op1 = 32'h1; i_immB = 12'hFFE; i_branch_taken = 0;
    i_fu_pc = 32'h80; i_stall = 1;
    for (int r = 0; r < 3; r++) begin
      step();
      check_all("stall");
    end
    i_stall = 0;
    step();
    chk("blt.flush", o_flush, 1'b1);
    chk("blt.bpc", o_branch_pc, 32'h7C);
    chk("blt.fupred", o_fu_pred_taken, 1'b1);
    check_all("blt");
    // one not-taken BLT must bring a once-written entry back below taken
    i_op0 = 32'h1; i_op1 = 32'hFFFF_FFFF;
    step();
    chk("blt.once", o_fu_pred_taken, 1'b0);
    check_all("blt_nt");

    // Bubble B-type with a mismatched prediction
    i_bubble = 1; i_funct3 = 3'b000; i_op0 = 3; i_op1 = 3; i_branch_taken = 0;
    step();
    chk("bubble.flush", o_flush, 1'b0);
    check_all("bubble");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      i_stall  = ($urandom_range(0, 5) == 0);
      i_bubble = ($urandom_range(0, 4) == 0);
      k = $urandom_range(0, 5);
      {i_is_j_type, i_is_jalr, i_is_b_type} = (k == 0) ? 3'b100 : (k == 1) ? 3'b010 :
                                              (k <= 3) ? 3'b001 : (k == 4) ? 3'b000 : 3'($urandom);
      i_pc     = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 15) == 0) i_pc = 32'hFFFF_FFFC;
      i_funct3 = 3'($urandom);
      i_op0    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
      i_op1    = ($urandom_range(0, 2) == 0) ? i_op0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
      i_immJ   = 20'($urandom); i_immI = 12'($urandom); i_immB = 12'($urandom);
      i_fu_pc  = 32'($urandom_range(0, 255)) << 2;
      resolve(kind_ok, is_ctl, legal, taken, tgt);
      i_branch_taken = ($urandom_range(0, 3) == 0) ? ~taken : taken;
      i_pred_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'(tgt);
      #1;
      chk("rand.fupred_pre", o_fu_pred_taken, m_bht[i_fu_pc[7:2]] >= 2);
      step();
      check_all("rand");
    end

    // Drive enough mispredicted JALs to saturate both statistics counters
    idle(); reset = 0;
    i_bubble = 0; i_is_j_type = 1; i_immJ = 20'h10; i_branch_taken = 0; i_pc = 32'h200;
    for (int n = 0; n < 65600; n++) step();
    chk("sat.mp", o_mispred_cnt, 16'hFFFF);
    chk("sat.br", o_br_cnt, 16'hFFFF);
    check_all("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
